// File: rtl/div_param.sv
// Iterative restoring divider, one quotient bit per cycle, with signed/unsigned
// modes, divide-by-zero and signed-overflow flags, abort and valid/ready handshake.
module div_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             annul_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             dbz_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sgn_q, sgn_d;
  logic             neg_dvd_q, neg_dvd_d;
  logic             neg_dvs_q, neg_dvs_d;
  logic             ovf_pend_q, ovf_pend_d;

  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;

  // Operand decode at accept time.
  logic             acc_neg_dvd, acc_neg_dvs, acc_ovf;
  logic [WIDTH-1:0] acc_dvd_mag, acc_dvs_mag;
  logic [WIDTH:0]   trial;

  assign acc_neg_dvd = signed_i & dividend_i[WIDTH-1];
  assign acc_neg_dvs = signed_i & divisor_i[WIDTH-1];
  // Two's-complement negation of MIN yields MIN, which read as unsigned is 2^(WIDTH-1).
  assign acc_dvd_mag = acc_neg_dvd ? ({WIDTH{1'b0}} - dividend_i) : dividend_i;
  assign acc_dvs_mag = acc_neg_dvs ? ({WIDTH{1'b0}} - divisor_i) : divisor_i;
  assign acc_ovf     = signed_i && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
                       && (divisor_i == {WIDTH{1'b1}});

  // Restoring step: shift the next dividend bit into the partial remainder and try a subtract.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch can be inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    sgn_d      = sgn_q;
    neg_dvd_d  = neg_dvd_q;
    neg_dvs_d  = neg_dvs_q;
    ovf_pend_d = ovf_pend_q;
    q_out_d    = q_out_q;
    r_out_d    = r_out_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sgn_d     = signed_i;
          neg_dvd_d = acc_neg_dvd;
          neg_dvs_d = acc_neg_dvs;
          if (divisor_i == '0) begin
            q_out_d = '1;
            r_out_d = dividend_i;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else begin
            quo_d      = acc_dvd_mag;
            rem_d      = '0;
            dvs_d      = acc_dvs_mag;
            cnt_d      = '0;
            ovf_pend_d = acc_ovf;
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          q_out_d = (sgn_q && (neg_dvd_q ^ neg_dvs_q)) ? ({WIDTH{1'b0}} - quo_q) : quo_q;
          r_out_d = (sgn_q && neg_dvd_q) ? ({WIDTH{1'b0}} - rem_q) : rem_q;
          dbz_d   = 1'b0;
          ovf_d   = ovf_pend_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          q_out_d = '0;
          r_out_d = '0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == CALC) || (state_d == FIX);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q     <= IDLE;
      q_out_q     <= '0;
      r_out_q     <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_out_q     <= q_out_d;
      r_out_q     <= r_out_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded at accept before use.
  always_ff @(posedge clk) begin
    cnt_q      <= cnt_d;
    quo_q      <= quo_d;
    rem_q      <= rem_d;
    dvs_q      <= dvs_d;
    sgn_q      <= sgn_d;
    neg_dvd_q  <= neg_dvd_d;
    neg_dvs_q  <= neg_dvs_d;
    ovf_pend_q <= ovf_pend_d;
  end

  assign in_ready_o  = in_ready_q;
  assign busy_o      = busy_q;
  assign out_valid_o = out_valid_q;
  assign quotient_o  = q_out_q;
  assign remainder_o = r_out_q;
  assign dbz_o       = dbz_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_div_param.sv
// Directed self-checking bench for div_param at WIDTH=32; expected values are
// hand-computed constants.
module tb_div_param;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         signed_i;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic         annul_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         dbz_o;
  logic         ovf_o;
  logic         busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  div_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .annul_i     (annul_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .dbz_o       (dbz_o),
    .ovf_o       (ovf_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency to out_valid_o, check the result, optionally
  // stall the consumer for `hold` cycles, then check the transfer clears the outputs.
  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_q,
                        input logic [W-1:0] exp_r, input logic exp_dbz,
                        input logic exp_ovf, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({tag, ".in_ready"}, in_ready_o, 1);
    signed_i    = sgn;
    dividend_i  = a;
    divisor_i   = b;
    in_valid_i  = 1'b1;
    out_ready_i = (hold == 0);
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid_i = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
        signed_i   = ~sgn;
      end
      if (out_valid_o) break;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".q"}, quotient_o, exp_q);
    check({tag, ".r"}, remainder_o, exp_r);
    check({tag, ".dbz"}, dbz_o, exp_dbz);
    check({tag, ".ovf"}, ovf_o, exp_ovf);
    if (hold > 0) begin
      annul_i    = 1'b1;
      in_valid_i = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check({tag, ".hold_valid"}, out_valid_o, 1);
        check({tag, ".hold_q"}, quotient_o, exp_q);
        check({tag, ".hold_r"}, remainder_o, exp_r);
      end
      annul_i     = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
    end
    @(negedge clk);
    check({tag, ".pulse_end"}, out_valid_o, 0);
    check({tag, ".q_clr"}, quotient_o, 0);
    check({tag, ".r_clr"}, remainder_o, 0);
    check({tag, ".flags_clr"}, {dbz_o, ovf_o}, 0);
    check({tag, ".ready_after"}, in_ready_o, 1);
  endtask

  initial begin
    int pulses;
    rst         = 1'b0;
    signed_i    = 1'b0;
    dividend_i  = '0;
    divisor_i   = '0;
    in_valid_i  = 1'b0;
    annul_i     = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.in_ready", in_ready_o, 1);
    check("reset.out_valid", out_valid_o, 0);
    check("reset.busy", busy_o, 0);
    check("reset.q", quotient_o, 0);
    check("reset.r", remainder_o, 0);
    check("reset.flags", {dbz_o, ovf_o}, 0);
    rst = 1'b1;

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34, 0);
    run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 34, 0);
    run_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 34, 0);
    run_op("s-100_-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0, 34, 0);
    run_op("s_min_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 34, 0);
    run_op("u_min_-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 34, 0);
    run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 34, 0);
    run_op("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 1, 0);
    run_op("s5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 1, 0);
    run_op("s-5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0, 1, 0);

    // Abort ten cycles into the calculation.
    @(negedge clk);
    signed_i   = 1'b0;
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    in_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_i = 1'b0;
    check("annul.busy_before", busy_o, 1);
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul.in_ready", in_ready_o, 1);
    check("annul.busy", busy_o, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid_o) pulses++;
    end
    check("annul.no_result", pulses, 0);
    run_op("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 34, 0);

    // Consumer stalls five cycles in DONE while annul_i/in_valid_i toggle.
    run_op("hold1234_10", 1'b0, 32'd1234, 32'd10, 32'd123, 32'd4, 1'b0, 1'b0, 34, 5);
    run_op("hold_dbz", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 1, 5);

    // Reset in the middle of a calculation.
    @(negedge clk);
    signed_i   = 1'b0;
    dividend_i = 32'd50;
    divisor_i  = 32'd5;
    in_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid.in_ready", in_ready_o, 1);
    check("rst_mid.busy", busy_o, 0);
    check("rst_mid.out_valid", out_valid_o, 0);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid_o) pulses++;
    end
    check("rst_mid.no_result", pulses, 0);
    check("rst_mid.ready_after", in_ready_o, 1);
    run_op("u77_7", 1'b0, 32'd77, 32'd7, 32'd11, 32'd0, 1'b0, 1'b0, 34, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
